// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: hazard/redirect controls, instruction-memory port, IF/ID register and status flags.
// master is the fetch unit side; slave is the pipeline/memory side that drives controls and returns words.
interface fetch_unit_if;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_target;
    logic [31:0] imem_address;
    logic [31:0] imem_instruction;
    logic [31:0] if_pc;
    logic [31:0] if_instruction;
    logic        if_valid;
    logic        halted;
    logic        out_of_range;
    logic        misalign_fault;

    modport master (
        input  stall, redirect, redirect_target, imem_instruction,
        output imem_address, if_pc, if_instruction, if_valid, halted, out_of_range, misalign_fault
    );

    modport slave (
        output stall, redirect, redirect_target, imem_instruction,
        input  imem_address, if_pc, if_instruction, if_valid, halted, out_of_range, misalign_fault
    );
endinterface

// File: rtl/fetch_unit.sv
// RV32I fetch stage: PC, IF/ID register, 1-cycle fetch latency; stall holds everything, redirect overrides stall.
// Optional FETCH_MISALIGN_TRAP_EN: misaligned redirect enters FAULT instead of being aligned down.
module fetch_unit #(
    parameter logic [31:0] TEXT_BASE = 32'h0040_0000,
    parameter int          MEM_WORDS = 256,
    parameter logic [31:0] NOP_WORD  = 32'h0000_0013
) (
    input  logic       clock,
    input  logic       reset,
    fetch_unit_if.master bus
);
    localparam logic [1:0] RUN   = 2'd0;
    localparam logic [1:0] HALT  = 2'd1;
`ifdef FETCH_MISALIGN_TRAP_EN
    localparam logic [1:0] FAULT = 2'd2;
`endif
    localparam logic [31:0] WINDOW_BYTES = 32'(4 * MEM_WORDS);

    logic [1:0]  state;
    logic [31:0] pc;
    logic [31:0] if_pc_q;
    logic [31:0] if_instruction_q;
    logic        if_valid_q;
    logic        halted_q;
    logic        out_of_range_q;
    logic [31:0] pc_offset;
    logic        in_window;
    logic        halt_word;

    // Offset compare avoids overflow at the top of the window.
    assign pc_offset = pc - TEXT_BASE;
    assign in_window = (pc_offset < WINDOW_BYTES);
    assign halt_word = (bus.imem_instruction[6:0] == 7'b1101111) &&
                       (bus.imem_instruction[31:12] == 20'd0);

`ifdef FETCH_MISALIGN_TRAP_EN
    logic misalign_q;
    assign bus.misalign_fault = misalign_q;
`else
    assign bus.misalign_fault = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state            <= RUN;
            pc               <= TEXT_BASE;
            if_pc_q          <= 32'd0;
            if_instruction_q <= NOP_WORD;
            if_valid_q       <= 1'b0;
            halted_q         <= 1'b0;
            out_of_range_q   <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
            misalign_q       <= 1'b0;
`endif
        end else begin
            case (state)
                RUN: begin
                    if (bus.redirect) begin
                        if_pc_q          <= 32'd0;
                        if_instruction_q <= NOP_WORD;
                        if_valid_q       <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
                        pc <= bus.redirect_target;
                        if (bus.redirect_target[1:0] != 2'b00) begin
                            state      <= FAULT;
                            misalign_q <= 1'b1;
                        end
`else
                        pc <= bus.redirect_target & ~32'd3;
`endif
                    end else if (!bus.stall) begin
                        if (!in_window) begin
                            if_pc_q          <= pc;
                            if_instruction_q <= NOP_WORD;
                            if_valid_q       <= 1'b0;
                            out_of_range_q   <= 1'b1;
                            pc               <= pc + 32'd4;
                        end else begin
                            if_pc_q          <= pc;
                            if_instruction_q <= bus.imem_instruction;
                            if_valid_q       <= 1'b1;
                            // Self-loop jal: let it retire, then freeze at the loop address.
                            if (halt_word) begin
                                state    <= HALT;
                                halted_q <= 1'b1;
                            end else begin
                                pc <= pc + 32'd4;
                            end
                        end
                    end
                end
                default: begin
                    if_instruction_q <= NOP_WORD;
                    if_valid_q       <= 1'b0;
                end
            endcase
        end
    end

    assign bus.imem_address   = pc;
    assign bus.if_pc          = if_pc_q;
    assign bus.if_instruction = if_instruction_q;
    assign bus.if_valid       = if_valid_q;
    assign bus.halted         = halted_q;
    assign bus.out_of_range   = out_of_range_q;
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: sequential fetch, stall, redirect, halt, out-of-range, misaligned redirect.
module tb_fetch_unit;
    localparam logic [31:0] BASE = 32'h0040_0000;
    localparam logic [31:0] NOP  = 32'h0000_0013;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] mem [0:255];

    fetch_unit_if bus ();

    fetch_unit #(.TEXT_BASE(BASE), .MEM_WORDS(256), .NOP_WORD(NOP)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    logic [31:0] word_off;
    assign word_off = bus.imem_address - BASE;
    assign bus.imem_instruction = (word_off < 32'd1024) ? mem[word_off[9:2]] : 32'hdead_beef;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic expect_if(input string tag, input logic [31:0] pc, input logic [31:0] ins, input logic vld);
        check_val({tag, "_pc"}, bus.if_pc, pc);
        check_val({tag, "_ins"}, bus.if_instruction, ins);
        check_val({tag, "_vld"}, {31'd0, bus.if_valid}, {31'd0, vld});
    endtask

    // Asynchronous reset pulse placed mid-cycle, then released just after an edge.
    task automatic pulse_reset(input string tag);
        @(posedge clock);
        #3;
        reset = 1'b1;
        #1;
        check_val({tag, "_rst_addr"}, bus.imem_address, BASE);
        check_val({tag, "_rst_oor"}, {31'd0, bus.out_of_range}, 32'd0);
        check_val({tag, "_rst_halt"}, {31'd0, bus.halted}, 32'd0);
        expect_if({tag, "_rst"}, 32'd0, NOP, 1'b0);
        tick();
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0000_0013 + (i << 20);
        mem[0]  = 32'h1001_0437;
        mem[1]  = 32'h0044_2483;
        mem[2]  = 32'h0094_84b3;
        mem[3]  = 32'h0084_2283;
        mem[14] = 32'h0010_0093;
        mem[18] = 32'h0000_00ef;
        bus.stall = 1'b0;
        bus.redirect = 1'b0;
        bus.redirect_target = 32'd0;

        // Reset state
        tick();
        tick();
        check_val("rst_addr", bus.imem_address, BASE);
        expect_if("rst", 32'd0, NOP, 1'b0);
        check_val("rst_halt", {31'd0, bus.halted}, 32'd0);
        check_val("rst_oor", {31'd0, bus.out_of_range}, 32'd0);
        check_val("rst_mis", {31'd0, bus.misalign_fault}, 32'd0);
        reset = 1'b0;

        // Sequential fetch
        tick(); expect_if("seq0", BASE,         32'h1001_0437, 1'b1);
        tick(); expect_if("seq1", BASE + 32'h4, 32'h0044_2483, 1'b1);
        tick(); expect_if("seq2", BASE + 32'h8, 32'h0094_84b3, 1'b1);

        // Stall for three cycles
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(); expect_if("stall", BASE + 32'h8, 32'h0094_84b3, 1'b1);
        end
        bus.stall = 1'b0;
        tick(); expect_if("seq3", BASE + 32'hC, 32'h0084_2283, 1'b1);

        // Redirect coincident with stall
        bus.stall = 1'b1;
        bus.redirect = 1'b1;
        bus.redirect_target = BASE + 32'h38;
        tick(); expect_if("redir_bub", 32'd0, NOP, 1'b0);
        check_val("redir_addr", bus.imem_address, BASE + 32'h38);
        bus.stall = 1'b0;
        bus.redirect = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick(); expect_if("redir_run", BASE + 32'h38 + 32'(4 * i), mem[14 + i], 1'b1);
        end

        // Halt word at 0x48
        tick(); expect_if("halt_cap", BASE + 32'h48, 32'h0000_00ef, 1'b1);
        check_val("halt_flag", {31'd0, bus.halted}, 32'd1);
        tick();
        check_val("halt_addr", bus.imem_address, BASE + 32'h48);
        check_val("halt_vld", {31'd0, bus.if_valid}, 32'd0);
        bus.redirect = 1'b1;
        bus.redirect_target = BASE;
        tick();
        check_val("halt_redir_addr", bus.imem_address, BASE + 32'h48);
        check_val("halt_redir_vld", {31'd0, bus.if_valid}, 32'd0);
        check_val("halt_redir_flag", {31'd0, bus.halted}, 32'd1);
        bus.redirect = 1'b0;

        // Fall-through past the end of the window
        pulse_reset("a");
        tick(); expect_if("b_seq0", BASE, 32'h1001_0437, 1'b1);
        bus.redirect = 1'b1;
        bus.redirect_target = BASE + 32'h3F8;
        tick();
        bus.redirect = 1'b0;
        tick(); expect_if("end0", BASE + 32'h3F8, mem[254], 1'b1);
        tick(); expect_if("end1", BASE + 32'h3FC, mem[255], 1'b1);
        check_val("end1_oor", {31'd0, bus.out_of_range}, 32'd0);
        tick();
        check_val("oor_vld", {31'd0, bus.if_valid}, 32'd0);
        check_val("oor_ins", bus.if_instruction, NOP);
        check_val("oor_flag", {31'd0, bus.out_of_range}, 32'd1);
        check_val("oor_addr", bus.imem_address, BASE + 32'h404);
        tick();
        check_val("oor_sticky", {31'd0, bus.out_of_range}, 32'd1);
        pulse_reset("b");

        // Redirect onto a halt word: redirect wins
        tick(); expect_if("c_seq0", BASE, 32'h1001_0437, 1'b1);
        bus.redirect = 1'b1;
        bus.redirect_target = BASE + 32'h44;
        tick();
        bus.redirect = 1'b0;
        tick(); expect_if("c_44", BASE + 32'h44, mem[17], 1'b1);
        check_val("c_addr48", bus.imem_address, BASE + 32'h48);
        bus.redirect = 1'b1;
        bus.redirect_target = BASE + 32'h38;
        tick();
        bus.redirect = 1'b0;
        expect_if("c_bub", 32'd0, NOP, 1'b0);
        check_val("c_nohalt", {31'd0, bus.halted}, 32'd0);
        check_val("c_addr38", bus.imem_address, BASE + 32'h38);
        pulse_reset("c");

        // Misaligned redirect
        tick(); expect_if("d_seq0", BASE, 32'h1001_0437, 1'b1);
        bus.redirect = 1'b1;
        bus.redirect_target = BASE + 32'h6;
        tick();
        bus.redirect = 1'b0;
        check_val("mis_bub_vld", {31'd0, bus.if_valid}, 32'd0);
`ifdef FETCH_MISALIGN_TRAP_EN
        check_val("mis_flag", {31'd0, bus.misalign_fault}, 32'd1);
        check_val("mis_addr", bus.imem_address, BASE + 32'h6);
        tick();
        check_val("mis_vld", {31'd0, bus.if_valid}, 32'd0);
        check_val("mis_halt", {31'd0, bus.halted}, 32'd0);
        check_val("mis_flag2", {31'd0, bus.misalign_fault}, 32'd1);
`else
        check_val("mis_flag", {31'd0, bus.misalign_fault}, 32'd0);
        check_val("mis_addr", bus.imem_address, BASE + 32'h4);
        tick(); expect_if("mis_run", BASE + 32'h4, 32'h0044_2483, 1'b1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
